// File: rtl/ipsxe_fft_mem_pkg.sv
// Shared definitions for the FFT distributed-RAM buffers: clear FSM states,
// byte-lane sizing and elaboration-time parameter range checks.
package ipsxe_fft_mem_pkg;

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_CLEAR = 1'b1
   } clr_state_e;

   function automatic int be_width(input int dw);
      return (dw + 7) / 8;
   endfunction

   function automatic bit rd_latency_ok(input int lat);
      return (lat >= 0) && (lat <= 2);
   endfunction

   function automatic bit addr_width_ok(input int aw);
      return (aw >= 4) && (aw <= 10);
   endfunction

   function automatic bit data_width_ok(input int dw);
      return (dw >= 1) && (dw <= 256);
   endfunction

endpackage

// File: rtl/ipsxe_fft_dist_sdpram_core.sv
// LUT-RAM array: one byte-lane-masked write port (user or clear engine) and
// one asynchronous read port.
module ipsxe_fft_dist_sdpram_core
   import ipsxe_fft_mem_pkg::*;
#(
   parameter int  ADDR_WIDTH = 6,
   parameter int  DATA_WIDTH = 32,
   localparam int BE_WIDTH   = be_width(DATA_WIDTH)
) (
   input  logic                  wr_clk,
   input  logic                  user_we,
   input  logic [BE_WIDTH-1:0]   user_be,
   input  logic [ADDR_WIDTH-1:0] user_addr,
   input  logic [DATA_WIDTH-1:0] user_data,
   input  logic                  clr_we,
   input  logic [ADDR_WIDTH-1:0] clr_addr,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [DATA_WIDTH-1:0] rd_word
);

   localparam int DEPTH = 2**ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic                  sel_we;
   logic [ADDR_WIDTH-1:0] sel_addr;
   logic [DATA_WIDTH-1:0] sel_data;
   logic [DATA_WIDTH-1:0] sel_mask;

   // The clear engine owns the port while it runs; user writes are already gated upstream.
   always_comb begin
      sel_we   = user_we;
      sel_addr = user_addr;
      sel_data = user_data;
      sel_mask = '0;
      for (int i = 0; i < DATA_WIDTH; i++) begin
         sel_mask[i] = user_be[i/8];
      end
      if (clr_we) begin
         sel_we   = 1'b1;
         sel_addr = clr_addr;
         sel_data = '0;
         sel_mask = '1;
      end
   end

   always_ff @(posedge wr_clk) begin
      if (sel_we) begin
         mem[sel_addr] <= (mem[sel_addr] & ~sel_mask) | (sel_data & sel_mask);
      end
   end

   assign rd_word = mem[rd_addr];

endmodule

// File: rtl/ipsxe_fft_dist_sdpram_v2.sv
// Simple dual-port distributed RAM for FFT buffers: clear engine FSM,
// read-during-write forwarding and a 0/1/2-cycle read pipeline.
module ipsxe_fft_dist_sdpram_v2
   import ipsxe_fft_mem_pkg::*;
#(
   parameter int  ADDR_WIDTH = 6,
   parameter int  DATA_WIDTH = 32,
   parameter int  RD_LATENCY = 1,
   parameter bit  WR_FWD     = 1'b1,
   parameter bit  CLR_ON_RST = 1'b1,
   localparam int BE_WIDTH   = be_width(DATA_WIDTH)
) (
   input  logic                  wr_clk,
   input  logic                  asyn_rst,
   input  logic                  clr_req,
   input  logic                  wr_en,
   input  logic [BE_WIDTH-1:0]   wr_be,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  rd_en,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  rd_valid,
   output logic                  busy,
   output logic                  clr_done
);

   localparam int                    DEPTH     = 2**ADDR_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

   if (!rd_latency_ok(RD_LATENCY)) begin : g_bad_latency
      $error("ipsxe_fft_dist_sdpram_v2: RD_LATENCY must be 0, 1 or 2");
   end
   if (!addr_width_ok(ADDR_WIDTH)) begin : g_bad_addr_width
      $error("ipsxe_fft_dist_sdpram_v2: ADDR_WIDTH must be in 4..10");
   end
   if (!data_width_ok(DATA_WIDTH)) begin : g_bad_data_width
      $error("ipsxe_fft_dist_sdpram_v2: DATA_WIDTH must be in 1..256");
   end

   clr_state_e            state_q;
   logic [ADDR_WIDTH-1:0] clr_cnt_q;
   logic                  clr_done_q;

   always_ff @(posedge wr_clk or posedge asyn_rst) begin
      if (asyn_rst) begin
         state_q    <= CLR_ON_RST ? ST_CLEAR : ST_IDLE;
         clr_cnt_q  <= '0;
         clr_done_q <= 1'b0;
      end else begin
         clr_done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (clr_req) begin
                  state_q   <= ST_CLEAR;
                  clr_cnt_q <= '0;
               end
            end
            ST_CLEAR: begin
               clr_cnt_q <= clr_cnt_q + 1'b1;
               if (clr_cnt_q == LAST_ADDR) begin
                  state_q    <= ST_IDLE;
                  clr_done_q <= 1'b1;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign busy     = (state_q == ST_CLEAR);
   assign clr_done = clr_done_q;

   logic                  user_we;
   logic                  rd_acc;
   logic [DATA_WIDTH-1:0] wr_mask;
   logic [DATA_WIDTH-1:0] mem_rd_word;
   logic [DATA_WIDTH-1:0] rd_raw_d;

   assign user_we = wr_en & ~busy;
   assign rd_acc  = rd_en & ~busy;

   always_comb begin
      wr_mask = '0;
      for (int i = 0; i < DATA_WIDTH; i++) begin
         wr_mask[i] = wr_be[i/8];
      end
   end

   ipsxe_fft_dist_sdpram_core #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH)
   ) u_core (
      .wr_clk    (wr_clk),
      .user_we   (user_we),
      .user_be   (wr_be),
      .user_addr (wr_addr),
      .user_data (wr_data),
      .clr_we    (busy),
      .clr_addr  (clr_cnt_q),
      .rd_addr   (rd_addr),
      .rd_word   (mem_rd_word)
   );

   // Forwarding reproduces the lane merge the array performs at the next edge.
   always_comb begin
      rd_raw_d = mem_rd_word;
      if (WR_FWD && user_we && (wr_addr == rd_addr)) begin
         rd_raw_d = (mem_rd_word & ~wr_mask) | (wr_data & wr_mask);
      end
   end

   if (RD_LATENCY == 0) begin : g_lat0
      assign rd_data  = rd_raw_d;
      assign rd_valid = rd_acc;
   end else begin : g_pipe
      logic [DATA_WIDTH-1:0] rd_data_p1_q;
      logic                  rd_vld_p1_q;

      // Stage 1: capture the raw word on accept, hold otherwise.
      always_ff @(posedge wr_clk or posedge asyn_rst) begin
         if (asyn_rst) begin
            rd_data_p1_q <= '0;
            rd_vld_p1_q  <= 1'b0;
         end else begin
            rd_vld_p1_q <= rd_acc;
            if (rd_acc) begin
               rd_data_p1_q <= rd_raw_d;
            end
         end
      end

      if (RD_LATENCY == 1) begin : g_lat1
         assign rd_data  = rd_data_p1_q;
         assign rd_valid = rd_vld_p1_q;
      end else begin : g_lat2
         logic [DATA_WIDTH-1:0] rd_data_p2_q;
         logic                  rd_vld_p2_q;

         // Stage 2: advance only valid stage-1 words.
         always_ff @(posedge wr_clk or posedge asyn_rst) begin
            if (asyn_rst) begin
               rd_data_p2_q <= '0;
               rd_vld_p2_q  <= 1'b0;
            end else begin
               rd_vld_p2_q <= rd_vld_p1_q;
               if (rd_vld_p1_q) begin
                  rd_data_p2_q <= rd_data_p1_q;
               end
            end
         end

         assign rd_data  = rd_data_p2_q;
         assign rd_valid = rd_vld_p2_q;
      end
   end

endmodule

// File: tb/tb_ipsxe_fft_dist_sdpram_v2.sv
// Bench for ipsxe_fft_dist_sdpram_v2: three configurations share one stimulus
// stream and are compared against a word-level memory model every cycle.
module tb_ipsxe_fft_dist_sdpram_v2;

   logic        clk = 1'b0;
   logic        asyn_rst = 1'b1;
   logic        clr_req = 1'b0;
   logic        wr_en = 1'b0;
   logic [3:0]  wr_be = 4'h0;
   logic [3:0]  wr_addr = 4'h0;
   logic [31:0] wr_data = 32'h0;
   logic        rd_en = 1'b0;
   logic [3:0]  rd_addr = 4'h0;

   logic [31:0] rd_data_l0, rd_data_l1, rd_data_l2;
   logic        rd_valid_l0, rd_valid_l1, rd_valid_l2;
   logic        busy_l0, busy_l1, busy_l2;
   logic        clr_done_l0, clr_done_l1, clr_done_l2;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   ipsxe_fft_dist_sdpram_v2 #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .RD_LATENCY(0),
                              .WR_FWD(1'b1), .CLR_ON_RST(1'b1)) u_l0 (
      .wr_clk(clk), .asyn_rst(asyn_rst), .clr_req(clr_req), .wr_en(wr_en),
      .wr_be(wr_be), .wr_addr(wr_addr), .wr_data(wr_data), .rd_en(rd_en),
      .rd_addr(rd_addr), .rd_data(rd_data_l0), .rd_valid(rd_valid_l0),
      .busy(busy_l0), .clr_done(clr_done_l0));

   ipsxe_fft_dist_sdpram_v2 #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .RD_LATENCY(1),
                              .WR_FWD(1'b1), .CLR_ON_RST(1'b1)) u_l1 (
      .wr_clk(clk), .asyn_rst(asyn_rst), .clr_req(clr_req), .wr_en(wr_en),
      .wr_be(wr_be), .wr_addr(wr_addr), .wr_data(wr_data), .rd_en(rd_en),
      .rd_addr(rd_addr), .rd_data(rd_data_l1), .rd_valid(rd_valid_l1),
      .busy(busy_l1), .clr_done(clr_done_l1));

   ipsxe_fft_dist_sdpram_v2 #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .RD_LATENCY(2),
                              .WR_FWD(1'b0), .CLR_ON_RST(1'b1)) u_l2 (
      .wr_clk(clk), .asyn_rst(asyn_rst), .clr_req(clr_req), .wr_en(wr_en),
      .wr_be(wr_be), .wr_addr(wr_addr), .wr_data(wr_data), .rd_en(rd_en),
      .rd_addr(rd_addr), .rd_data(rd_data_l2), .rd_valid(rd_valid_l2),
      .busy(busy_l2), .clr_done(clr_done_l2));

   // Reference model: word array, remaining clear cycles, and delayed read results.
   logic [31:0] mem_m [16];
   int          clr_left;
   bit          done_m;
   bit          h1_v, h2a_v, h2b_v;
   logic [31:0] h1_d, h2a_d, h2b_d;

   typedef struct {
      logic        we;
      logic [3:0]  be;
      logic [3:0]  wa;
      logic [31:0] wd;
      logic        re;
      logic [3:0]  ra;
      logic [31:0] exp_fwd;
      logic [31:0] exp_old;
   } vec_t;

   vec_t vecs[12];

   function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                         input logic [3:0] be);
      logic [31:0] r;
      r = old_w;
      for (int k = 0; k < 4; k++) begin
         if (be[k]) r[8*k +: 8] = new_w[8*k +: 8];
      end
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic set_idle();
      clr_req = 1'b0;
      wr_en   = 1'b0;
      wr_be   = 4'h0;
      rd_en   = 1'b0;
   endtask

   task automatic model_reset();
      clr_left = 16;
      done_m   = 1'b0;
      h1_v     = 1'b0;
      h2a_v    = 1'b0;
      h2b_v    = 1'b0;
      h1_d     = 32'h0;
      h2a_d    = 32'h0;
      h2b_d    = 32'h0;
   endtask

   // One clock cycle: compare all outputs with the model, then advance the model.
   task automatic tick();
      bit          busy_m, acc, wr;
      logic [31:0] merged, raw_new, raw_old;
      #1;
      busy_m  = (clr_left > 0);
      acc     = rd_en && !busy_m;
      wr      = wr_en && !busy_m;
      merged  = merge(mem_m[wr_addr], wr_data, wr_be);
      raw_old = mem_m[rd_addr];
      raw_new = (wr && (wr_addr == rd_addr)) ? merged : raw_old;
      chk("busy_l0", 32'(busy_l0), 32'(busy_m));
      chk("busy_l1", 32'(busy_l1), 32'(busy_m));
      chk("busy_l2", 32'(busy_l2), 32'(busy_m));
      chk("clr_done_l1", 32'(clr_done_l1), 32'(done_m));
      chk("clr_done_l2", 32'(clr_done_l2), 32'(done_m));
      chk("rd_valid_l0", 32'(rd_valid_l0), 32'(acc));
      if (acc) chk("rd_data_l0", rd_data_l0, raw_new);
      chk("rd_valid_l1", 32'(rd_valid_l1), 32'(h1_v));
      if (h1_v) chk("rd_data_l1", rd_data_l1, h1_d);
      chk("rd_valid_l2", 32'(rd_valid_l2), 32'(h2b_v));
      if (h2b_v) chk("rd_data_l2", rd_data_l2, h2b_d);
      @(posedge clk);
      if (busy_m) begin
         mem_m[16 - clr_left] = 32'h0;
         clr_left--;
         done_m = (clr_left == 0);
      end else begin
         done_m = 1'b0;
         if (clr_req) clr_left = 16;
      end
      if (wr) mem_m[wr_addr] = merged;
      h2b_v = h2a_v;
      h2b_d = h2a_d;
      h2a_v = acc;
      h2a_d = raw_old;
      h1_v  = acc;
      if (acc) h1_d = raw_new;
      @(negedge clk);
   endtask

   task automatic reset_outputs_check(input string tag);
      chk({tag, "_rd_data_l1"}, rd_data_l1, 32'h0);
      chk({tag, "_rd_data_l2"}, rd_data_l2, 32'h0);
      chk({tag, "_rd_valid_l0"}, 32'(rd_valid_l0), 32'h0);
      chk({tag, "_rd_valid_l1"}, 32'(rd_valid_l1), 32'h0);
      chk({tag, "_rd_valid_l2"}, 32'(rd_valid_l2), 32'h0);
      chk({tag, "_clr_done"}, 32'(clr_done_l1), 32'h0);
      chk({tag, "_busy"}, 32'(busy_l1), 32'h1);
   endtask

   // Counts busy cycles and clr_done pulses over a fixed window after a sweep starts.
   task automatic sweep_watch(input string tag);
      int n_busy, n_done;
      n_busy = 0;
      n_done = 0;
      for (int n = 0; n < 24; n++) begin
         #1;
         if (busy_l1) n_busy++;
         if (clr_done_l1) begin
            n_done++;
            chk({tag, "_done_after_busy"}, 32'(n), 32'd16);
         end
         tick();
      end
      chk({tag, "_busy_cycles"}, 32'(n_busy), 32'd16);
      chk({tag, "_done_pulses"}, 32'(n_done), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n_busy, n_bad;
      for (int i = 0; i < 16; i++) mem_m[i] = 32'h0;
      vecs[0]  = '{1'b1, 4'hF, 4'd3, 32'hDEADBEEF, 1'b0, 4'd0, 32'h0,        32'h0};
      vecs[1]  = '{1'b0, 4'h0, 4'd0, 32'h0,        1'b1, 4'd3, 32'hDEADBEEF, 32'hDEADBEEF};
      vecs[2]  = '{1'b1, 4'h5, 4'd3, 32'h11223344, 1'b0, 4'd0, 32'h0,        32'h0};
      vecs[3]  = '{1'b0, 4'h0, 4'd0, 32'h0,        1'b1, 4'd3, 32'hDE22BE44, 32'hDE22BE44};
      vecs[4]  = '{1'b1, 4'hF, 4'd5, 32'hCAFEF00D, 1'b1, 4'd5, 32'hCAFEF00D, 32'h00000000};
      vecs[5]  = '{1'b0, 4'h0, 4'd0, 32'h0,        1'b1, 4'd5, 32'hCAFEF00D, 32'hCAFEF00D};
      vecs[6]  = '{1'b1, 4'h0, 4'd6, 32'hFFFFFFFF, 1'b1, 4'd6, 32'h00000000, 32'h00000000};
      vecs[7]  = '{1'b1, 4'h8, 4'd7, 32'h12345678, 1'b1, 4'd7, 32'h12000000, 32'h00000000};
      vecs[8]  = '{1'b0, 4'h0, 4'd0, 32'h0,        1'b1, 4'd7, 32'h12000000, 32'h12000000};
      vecs[9]  = '{1'b1, 4'h6, 4'd7, 32'hAABBCCDD, 1'b1, 4'd3, 32'hDE22BE44, 32'hDE22BE44};
      vecs[10] = '{1'b0, 4'h0, 4'd0, 32'h0,        1'b1, 4'd7, 32'h12BBCC00, 32'h12BBCC00};
      vecs[11] = '{1'b0, 4'h0, 4'd0, 32'h0,        1'b1, 4'd6, 32'h00000000, 32'h00000000};

      // Power-on reset, then the automatic sweep.
      asyn_rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      reset_outputs_check("por");
      model_reset();
      asyn_rst = 1'b0;
      sweep_watch("por");

      // Every address reads zero, valid one cycle after each request.
      for (int i = 0; i < 16; i++) begin
         rd_en   = 1'b1;
         rd_addr = 4'(i);
         tick();
         chk("clr_zero_valid", 32'(rd_valid_l1), 32'h1);
         chk("clr_zero_data", rd_data_l1, 32'h0);
      end
      set_idle();
      tick();
      tick();

      // Table of writes, lane merges and read-during-write cases.
      foreach (vecs[i]) begin
         wr_en = vecs[i].we; wr_be = vecs[i].be; wr_addr = vecs[i].wa;
         wr_data = vecs[i].wd; rd_en = vecs[i].re; rd_addr = vecs[i].ra;
         #1;
         if (vecs[i].re) chk($sformatf("vec%0d_l0", i), rd_data_l0, vecs[i].exp_fwd);
         tick();
         set_idle();
         #1;
         if (vecs[i].re) begin
            chk($sformatf("vec%0d_l1_valid", i), 32'(rd_valid_l1), 32'h1);
            chk($sformatf("vec%0d_l1", i), rd_data_l1, vecs[i].exp_fwd);
         end
         tick();
         if (vecs[i].re) begin
            chk($sformatf("vec%0d_l2_valid", i), 32'(rd_valid_l2), 32'h1);
            chk($sformatf("vec%0d_l2", i), rd_data_l2, vecs[i].exp_old);
         end
      end

      // Back-to-back reads of a preloaded block.
      for (int i = 0; i < 4; i++) begin
         wr_en = 1'b1; wr_be = 4'hF; wr_addr = 4'(i); wr_data = 32'hA0 + 32'(i);
         tick();
      end
      set_idle();
      for (int c = 0; c < 7; c++) begin
         rd_en   = (c < 4);
         rd_addr = 4'(c);
         #1;
         chk($sformatf("b2b_l0_valid%0d", c), 32'(rd_valid_l0), 32'(c < 4));
         if (c < 4) chk($sformatf("b2b_l0_data%0d", c), rd_data_l0, 32'hA0 + 32'(c));
         chk($sformatf("b2b_l2_valid%0d", c), 32'(rd_valid_l2), 32'((c >= 2) && (c < 6)));
         if ((c >= 2) && (c < 6)) chk($sformatf("b2b_l2_data%0d", c), rd_data_l2, 32'hA0 + 32'(c - 2));
         tick();
      end
      set_idle();

      // Requested sweep with blocked writes/reads and an ignored second request.
      clr_req = 1'b1;
      tick();
      clr_req = 1'b0;
      n_busy = 0;
      n_bad  = 0;
      for (int n = 0; n < 40; n++) begin
         if (!busy_l1) break;
         n_busy++;
         wr_en = 1'b1; wr_be = 4'hF; wr_addr = 4'd2; wr_data = 32'hFFFFFFFF;
         rd_en = 1'b1; rd_addr = 4'd2; clr_req = (n == 8);
         #1;
         if (rd_valid_l0 || rd_valid_l1 || rd_valid_l2) n_bad++;
         tick();
      end
      set_idle();
      chk("req_busy_cycles", 32'(n_busy), 32'd16);
      chk("req_valid_while_busy", 32'(n_bad), 32'd0);
      #1;
      chk("req_clr_done", 32'(clr_done_l1), 32'h1);
      tick();
      chk("req_clr_done_drop", 32'(clr_done_l1), 32'h0);
      rd_en = 1'b1; rd_addr = 4'd2;
      tick();
      set_idle();
      chk("req_addr2_valid", 32'(rd_valid_l1), 32'h1);
      chk("req_addr2_zero", rd_data_l1, 32'h0);
      tick();

      // Reset while the clear counter is at 7.
      wr_en = 1'b1; wr_be = 4'hF; wr_addr = 4'd9; wr_data = 32'h55AA55AA;
      tick();
      set_idle();
      rd_en = 1'b1; rd_addr = 4'd9; clr_req = 1'b1;
      tick();
      set_idle();
      for (int n = 0; n < 7; n++) tick();
      chk("mid_hold_l1", rd_data_l1, 32'h55AA55AA);
      chk("mid_hold_l2", rd_data_l2, 32'h55AA55AA);
      asyn_rst = 1'b1;
      #1;
      reset_outputs_check("mid");
      model_reset();
      @(negedge clk);
      @(negedge clk);
      asyn_rst = 1'b0;
      sweep_watch("mid");

      // Random traffic against the model.
      for (int n = 0; n < 500; n++) begin
         wr_en   = 1'($urandom_range(0, 1));
         wr_be   = 4'($urandom);
         wr_addr = 4'($urandom);
         wr_data = $urandom;
         rd_en   = 1'($urandom_range(0, 1));
         rd_addr = ($urandom_range(0, 3) == 0) ? wr_addr : 4'($urandom);
         clr_req = ($urandom_range(0, 99) == 0);
         tick();
      end
      set_idle();
      for (int n = 0; n < 20; n++) tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
